// File: rtl/cpu_pkg.sv
// Types and constants shared across the CPU core blocks.
package cpu_pkg;

    typedef enum logic {
        FLG_SRC_ALU  = 1'b0,
        FLG_SRC_SHAD = 1'b1
    } flg_ld_sel_t;

    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/int_sync.sv
// Synchronizer for the asynchronous interrupt line, with a one-cycle
// history flop for rising-edge detection.
module int_sync #(
    parameter int SYNC_STAGES = cpu_pkg::SYNC_STAGES_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic INT_IN,
    output logic s_int,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], INT_IN};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_int = sync_q[SYNC_STAGES-1];
    // History resets to 0, so a line held high through reset yields one edge.
    assign rise  = s_int & ~prev_q;

endmodule

// File: rtl/flag_intr_unit.sv
// C/Z/I flags with shadow copies, and the pending-interrupt latch that
// produces INTERRUPT for the control unit.
module flag_intr_unit
    import cpu_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter bit INT_EDGE    = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ALU_C,
    input  logic ALU_Z,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_C_LD,
    input  logic FLG_Z_LD,
    input  logic FLG_LD_SEL,
    input  logic FLG_SHAD_LD,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INT_IN,
    input  logic INT_ACK,
    output logic C,
    output logic Z,
    output logic I_EN,
    output logic INT_PEND,
    output logic INTERRUPT
);

    logic        c_q, c_d;
    logic        z_q, z_d;
    logic        shad_c_q, shad_c_d;
    logic        shad_z_q, shad_z_d;
    logic        i_en_q, i_en_d;
    logic        pend_q, pend_d;
    logic        s_int, rise;
    flg_ld_sel_t ld_sel;

    int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .INT_IN(INT_IN),
        .s_int (s_int),
        .rise  (rise)
    );

    assign ld_sel = flg_ld_sel_t'(FLG_LD_SEL);

    always_comb begin
        c_d = c_q;
        if (FLG_C_CLR)
            c_d = 1'b0;
        else if (FLG_C_SET)
            c_d = 1'b1;
        else if (FLG_C_LD)
            c_d = (ld_sel == FLG_SRC_SHAD) ? shad_c_q : ALU_C;

        z_d = z_q;
        if (FLG_Z_LD)
            z_d = (ld_sel == FLG_SRC_SHAD) ? shad_z_q : ALU_Z;

        // Shadow always takes pre-edge flags, which makes a simultaneous
        // shadow load plus shadow-sourced flag load a swap.
        shad_c_d = FLG_SHAD_LD ? c_q : shad_c_q;
        shad_z_d = FLG_SHAD_LD ? z_q : shad_z_q;

        i_en_d = i_en_q;
        if (I_CLR)
            i_en_d = 1'b0;
        else if (I_SET)
            i_en_d = 1'b1;

        // A new edge beats an acknowledge so it is never dropped.
        if (INT_EDGE)
            pend_d = rise ? 1'b1 : (INT_ACK ? 1'b0 : pend_q);
        else
            pend_d = s_int;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            shad_c_q <= 1'b0;
            shad_z_q <= 1'b0;
            i_en_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            c_q      <= c_d;
            z_q      <= z_d;
            shad_c_q <= shad_c_d;
            shad_z_q <= shad_z_d;
            i_en_q   <= i_en_d;
            pend_q   <= pend_d;
        end
    end

    assign C         = c_q;
    assign Z         = z_q;
    assign I_EN      = i_en_q;
    assign INT_PEND  = pend_q;
    assign INTERRUPT = pend_q & i_en_q;

endmodule

// File: tb/tb_flag_intr_unit.sv
// Bench for flag_intr_unit: directed steps push the expected
// {C,Z,I_EN,INT_PEND,INTERRUPT} into a queue, checked after each edge.
module tb_flag_intr_unit;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic ALU_C = 1'b0, ALU_Z = 1'b0;
    logic FLG_C_SET = 1'b0, FLG_C_CLR = 1'b0, FLG_C_LD = 1'b0, FLG_Z_LD = 1'b0;
    logic FLG_LD_SEL = 1'b0, FLG_SHAD_LD = 1'b0;
    logic I_SET = 1'b0, I_CLR = 1'b0;
    logic INT_IN = 1'b0, INT_ACK = 1'b0;
    logic C, Z, I_EN, INT_PEND, INTERRUPT;

    typedef struct {
        string      tag;
        logic [4:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    flag_intr_unit #(.SYNC_STAGES(2), .INT_EDGE(1'b1)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ALU_C      (ALU_C),
        .ALU_Z      (ALU_Z),
        .FLG_C_SET  (FLG_C_SET),
        .FLG_C_CLR  (FLG_C_CLR),
        .FLG_C_LD   (FLG_C_LD),
        .FLG_Z_LD   (FLG_Z_LD),
        .FLG_LD_SEL (FLG_LD_SEL),
        .FLG_SHAD_LD(FLG_SHAD_LD),
        .I_SET      (I_SET),
        .I_CLR      (I_CLR),
        .INT_IN     (INT_IN),
        .INT_ACK    (INT_ACK),
        .C          (C),
        .Z          (Z),
        .I_EN       (I_EN),
        .INT_PEND   (INT_PEND),
        .INTERRUPT  (INTERRUPT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got CZIPX=%b expected %b", tag, got, exp);
        end
    endtask

    // Push the expectation for the coming edge, clock, then pop and compare.
    task automatic step(input string tag, input logic [4:0] exp);
        exp_t e;
        e.tag = tag;
        e.v   = exp;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check_eq(e.tag, {C, Z, I_EN, INT_PEND, INTERRUPT}, e.v);
        end
        RESET = 1'b0;
        FLG_C_SET = 1'b0; FLG_C_CLR = 1'b0; FLG_C_LD = 1'b0; FLG_Z_LD = 1'b0;
        FLG_SHAD_LD = 1'b0; I_SET = 1'b0; I_CLR = 1'b0; INT_ACK = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b1;                              step("rst",      5'b00000);

        // Reset beats strobes
        FLG_C_SET = 1; I_SET = 1;                  step("set",      5'b10100);
        RESET = 1; FLG_C_SET = 1; I_SET = 1;       step("rst_win",  5'b00000);

        // C priority
        FLG_C_LD = 1; ALU_C = 1; FLG_C_CLR = 1;    step("cpri_clr", 5'b00000);
        FLG_C_SET = 1; FLG_C_LD = 1; ALU_C = 0;    step("cpri_set", 5'b10000);

        // Shadow save / overwrite / restore
        FLG_SHAD_LD = 1;                           step("save",     5'b10000);
        FLG_LD_SEL = 0; ALU_C = 0; ALU_Z = 1;
        FLG_C_LD = 1; FLG_Z_LD = 1;                step("ovr",      5'b01000);
        FLG_LD_SEL = 1; FLG_C_LD = 1; FLG_Z_LD = 1; step("restore", 5'b10000);
        FLG_LD_SEL = 0; FLG_C_LD = 1; FLG_Z_LD = 1; step("ovr2",    5'b01000);
        FLG_LD_SEL = 1; FLG_SHAD_LD = 1;
        FLG_C_LD = 1; FLG_Z_LD = 1;                step("swap",     5'b10000);
        FLG_C_LD = 1; FLG_Z_LD = 1;                step("swap_back", 5'b01000);
        FLG_LD_SEL = 0; ALU_C = 1; ALU_Z = 0;      step("hold",     5'b01000);

        // I_EN priority
        I_SET = 1; I_CLR = 1;                      step("ipri_clr", 5'b01000);
        I_SET = 1;                                 step("iset",     5'b01100);

        // Edge latency: pending two edges after the one that sees INT_IN
        INT_IN = 1;                                step("lat0",     5'b01100);
                                                   step("lat1",     5'b01100);
                                                   step("lat2",     5'b01111);
                                                   step("pend_hold", 5'b01111);
        INT_ACK = 1;                               step("ack",      5'b01100);
                                                   step("noretrig1", 5'b01100);
                                                   step("noretrig2", 5'b01100);

        // Masked edge stays pending
        I_CLR = 1; INT_IN = 0;                     step("mask",     5'b01000);
                                                   step("low1",     5'b01000);
                                                   step("low2",     5'b01000);
        INT_IN = 1;                                step("m_lat0",   5'b01000);
                                                   step("m_lat1",   5'b01000);
                                                   step("masked",   5'b01010);
        I_SET = 1;                                 step("unmask",   5'b01111);

        // Ack colliding with a fresh rise keeps the request
        INT_ACK = 1; INT_IN = 0;                   step("ack2",     5'b01100);
                                                   step("fall1",    5'b01100);
                                                   step("fall2",    5'b01100);
        INT_IN = 1;                                step("c_lat0",   5'b01100);
                                                   step("c_lat1",   5'b01100);
        INT_ACK = 1;                               step("collide",  5'b01111);
        INT_ACK = 1;                               step("ack3",     5'b01100);

        // Reset mid-operation with INT_IN high: exactly one request after
        RESET = 1; FLG_C_SET = 1; I_SET = 1;       step("rst_mid",  5'b00000);
                                                   step("pr_lat0",  5'b00000);
                                                   step("pr_lat1",  5'b00000);
                                                   step("post_rst", 5'b00010);
        INT_ACK = 1;                               step("pr_ack",   5'b00000);
                                                   step("one_only", 5'b00000);
                                                   step("one_only2", 5'b00000);

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
